// File: rtl/led_shift_driver_pkg.sv
// rtl/led_shift_driver_pkg.sv - shared FSM state encoding for the LED shift-out driver
package led_shift_driver_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        LATCH = ST_LATCH,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/led_shift_driver_sclk_div_tick.sv
// rtl/led_shift_driver_sclk_div_tick.sv - DIV-cycle enable generator pacing sclk half-periods
module sclk_div_tick
    import led_shift_driver_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TERM);

    // Reloads on every tick so each state starts a fresh half-period from zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_shift_driver.sv
// rtl/led_shift_driver.sv - shifts a snapshotted word into a 74HC595-style chain on each sync edge
module led_shift_driver
    import led_shift_driver_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DIV       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sclk_o,
    output logic             sdo_o,
    output logic             latch_o,
    output logic             clr_n_o
);

    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic             sync_q;
    logic             trigger;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_adv;
    logic [BW-1:0]    bit_cnt;
    logic             tick;
    logic             div_en;
    logic             div_clr;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    assign trigger   = sync_i & ~sync_q;
    assign div_en    = (state == SHIFT) || (state == LATCH);
    assign div_clr   = (state == IDLE) || (state == DONE);
    assign shreg_adv = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    sclk_div_tick #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr),
        .en    (div_en),
        .tick  (tick)
    );

    // sync_q resets high so a level already present at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sync_q  <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            sclk_o  <= 1'b0;
            sdo_o   <= 1'b0;
            latch_o <= 1'b0;
            clr_n_o <= 1'b0;
        end else begin
            sync_q  <= sync_i;
            clr_n_o <= 1'b1;
            done_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        shreg   <= data_i;
                        bit_cnt <= '0;
                        sdo_o   <= first_bit(data_i);
                        sclk_o  <= 1'b0;
                        busy_o  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk_o) begin
                            sclk_o <= 1'b1;
                        end else begin
                            // Falling sclk and the next data bit change on the same edge.
                            sclk_o <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                sdo_o   <= 1'b0;
                                latch_o <= 1'b1;
                                state   <= LATCH;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                shreg   <= shreg_adv;
                                sdo_o   <= first_bit(shreg_adv);
                            end
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        latch_o <= 1'b0;
                        done_o  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_shift_driver.sv
// tb/tb_led_shift_driver.sv - self-checking bench for led_shift_driver across three parameter sets
module tb_led_shift_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sync;
    logic [15:0] d0, d1;
    logic [1:0]  d2;
    logic [2:0]  busy, done, sclk, sdo, latch, clr_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_shift_driver #(.WIDTH(16), .DIV(2), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .sync_i(sync[0]), .data_i(d0),
        .busy_o(busy[0]), .done_o(done[0]), .sclk_o(sclk[0]), .sdo_o(sdo[0]),
        .latch_o(latch[0]), .clr_n_o(clr_n[0])
    );

    led_shift_driver #(.WIDTH(16), .DIV(2), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .sync_i(sync[1]), .data_i(d1),
        .busy_o(busy[1]), .done_o(done[1]), .sclk_o(sclk[1]), .sdo_o(sdo[1]),
        .latch_o(latch[1]), .clr_n_o(clr_n[1])
    );

    led_shift_driver #(.WIDTH(2), .DIV(1), .MSB_FIRST(1)) u_small (
        .clk(clk), .rst_n(rst_n), .sync_i(sync[2]), .data_i(d2),
        .busy_o(busy[2]), .done_o(done[2]), .sclk_o(sclk[2]), .sdo_o(sdo[2]),
        .latch_o(latch[2]), .clr_n_o(clr_n[2])
    );

    typedef struct {
        int          inst;
        logic [15:0] data;
        int          hold;
        bit          repulse;
        logic [15:0] exp_serial;
    } vec_t;

    vec_t vecs[10];

    function automatic int inst_w(input int i);
        return (i == 2) ? 2 : 16;
    endfunction

    function automatic int inst_div(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic logic [5:0] outs(input int i);
        return {busy[i], done[i], sclk[i], sdo[i], latch[i], clr_n[i]};
    endfunction

    function automatic logic [15:0] reverse16(input logic [15:0] v);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[k] = v[15-k];
        return r;
    endfunction

    // Expected {busy,done,sclk,sdo,latch,clr_n} at cycle c after the trigger edge (c=1 is first).
    function automatic logic [5:0] model(input int w, input int div, input bit msb,
                                         input logic [15:0] d, input int c);
        int shift_len, idx, ph;
        logic b;
        shift_len = 2 * div * w;
        if (c >= 1 && c <= shift_len) begin
            idx = (c - 1) / (2 * div);
            ph  = (c - 1) % (2 * div);
            b   = msb ? d[w-1-idx] : d[idx];
            return {1'b1, 1'b0, (ph >= div), b, 1'b0, 1'b1};
        end else if (c > shift_len && c <= shift_len + div) begin
            return 6'b100011;
        end else if (c == shift_len + div + 1) begin
            return 6'b110001;
        end
        return 6'b000001;
    endfunction

    task automatic check(input string name, input int c, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got {busy,done,sclk,sdo,latch,clr_n}=%b expected %b", name, c, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [15:0] v);
        case (i)
            0:       d0 = v;
            1:       d1 = v;
            default: d2 = v[1:0];
        endcase
    endtask

    task automatic run_frame(input int i, input logic [15:0] d, input int hold,
                             input bit repulse, input logic [15:0] exp_serial, input string name);
        int w, div, len, rises;
        bit msb;
        logic [15:0] ser, mask;
        logic prev_sclk;
        w    = inst_w(i);
        div  = inst_div(i);
        msb  = (i != 1);
        len  = 2 * div * w + div + 1;
        mask = 16'((32'd1 << w) - 1);
        @(negedge clk);
        sync[i] = 1'b0;
        @(negedge clk);
        set_data(i, d);
        sync[i] = 1'b1;
        ser = '0;
        rises = 0;
        prev_sclk = 1'b0;
        for (int c = 1; c <= len + 6; c++) begin
            @(negedge clk);
            check(name, c, outs(i), model(w, div, msb, d, c));
            if (sclk[i] && !prev_sclk) begin
                ser = {ser[14:0], sdo[i]};
                rises++;
            end
            prev_sclk = sclk[i];
            if (c == hold) sync[i] = 1'b0;
            if (repulse && (c == 20 || c == 40)) sync[i] = 1'b1;
            if (repulse && (c == 21 || c == 41)) sync[i] = 1'b0;
            if (c == 5) set_data(i, 16'($urandom));
        end
        sync[i] = 1'b0;
        check_val({name, " serial"}, int'(ser & mask), int'(exp_serial & mask));
        check_val({name, " rises"}, rises, w);
    endtask

    initial begin
        rst_n = 1'b0;
        sync  = '0;
        d0 = '0; d1 = '0; d2 = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check("reset", 0, outs(i), 6'b000000);
        rst_n = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) check("idle_after_reset", c, outs(i), 6'b000001);
        end

        vecs[0] = '{0, 16'hA5C3, 1, 1'b0, 16'hA5C3};
        vecs[1] = '{1, 16'h0001, 1, 1'b0, 16'h8000};
        vecs[2] = '{2, 16'h0002, 1, 1'b0, 16'h0002};
        vecs[3] = '{0, 16'h3C5A, 2, 1'b1, 16'h3C5A};
        vecs[4] = '{0, 16'hFFFF, 200, 1'b0, 16'hFFFF};
        vecs[5] = '{2, 16'h0001, 200, 1'b0, 16'h0001};
        for (int k = 6; k < 10; k++) begin
            vecs[k].inst    = k % 3;
            vecs[k].data    = 16'($urandom);
            vecs[k].hold    = 1 + (k % 2);
            vecs[k].repulse = (k == 6);
            vecs[k].exp_serial = (vecs[k].inst == 1) ? reverse16(vecs[k].data) : vecs[k].data;
        end
        for (int k = 0; k < 10; k++) begin
            run_frame(vecs[k].inst, vecs[k].data, vecs[k].hold, vecs[k].repulse,
                      vecs[k].exp_serial, $sformatf("vec%0d", k));
        end

        // Reset mid-frame, with sync held high through release.
        @(negedge clk);
        sync[0] = 1'b0;
        @(negedge clk);
        d0 = 16'hFFFF;
        sync[0] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            check("pre_abort", c, outs(0), model(16, 2, 1'b1, 16'hFFFF, c));
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_reset", 31, outs(0), 6'b000000);
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check("held_sync_no_trigger", c, outs(0), 6'b000001);
        end
        sync[0] = 1'b0;
        run_frame(0, 16'h1234, 1, 1'b0, 16'h1234, "post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
